alu_issue_ctrl: RTL

//  Issue/writeback controller directly upstream of the 3-bit-select 32-bit ALU.

---
 rtl/alu_issue_ctrl_if.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, ALU, writeback and debug signals of the issue controller
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int AW = 3
);
  logic instr_valid;
  logic instr_ready;
  logic [2:0] instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic [2:0] alu_sel;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] alu_out;
  logic alu_co;
  logic wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic carry_flag;
  logic illegal_op;
  logic [AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  modport slave (
    input instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, alu_out, alu_co, dbg_addr,
    output instr_ready, alu_sel, alu_in1, alu_in2, wb_valid, wb_rd, wb_data, carry_flag, illegal_op, dbg_data
  );
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, alu_out, alu_co, dbg_addr,
    input instr_ready, alu_sel, alu_in1, alu_in2, wb_valid, wb_rd, wb_data, carry_flag, illegal_op, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences read/exec/writeback of one instruction at a time around an external ALU
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int NREG = 8,
  parameter int AW = 3
) (
  input logic clk,
  input logic rst,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_ERR} state_t;
  state_t r_state, w_next;
  logic [2:0] r_op;
  logic [AW-1:0] r_rd, r_rs1, r_rs2;
  logic [2:0] r_sel;
  logic [DATA_W-1:0] r_in1, r_in2, r_res;
  logic r_co, r_carry;
  logic [DATA_W-1:0] r_rf [NREG];
  logic w_accept;
  assign w_accept = (r_state == S_IDLE) && bus.instr_valid;
  assign bus.instr_ready = r_state == S_IDLE;
  assign bus.wb_valid = r_state == S_WB;
  assign bus.wb_rd = (r_state == S_WB) ? r_rd : '0;
  assign bus.wb_data = (r_state == S_WB) ? r_res : '0;
  assign bus.illegal_op = r_state == S_ERR;
  assign bus.carry_flag = r_carry;
  assign bus.alu_sel = r_sel;
  assign bus.alu_in1 = r_in1;
  assign bus.alu_in2 = r_in2;
  assign bus.dbg_data = r_rf[bus.dbg_addr];
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next state: illegal op 7 detours through ERR instead of the datapath
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_accept ? ((bus.instr_op == 3'd7) ? S_ERR : S_READ) : S_IDLE;
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      default: w_next = S_IDLE;
    endcase
  end
  // latch the instruction on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= '0;
      r_rd <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
    end else if (w_accept) begin
      r_op <= bus.instr_op;
      r_rd <= bus.instr_rd;
      r_rs1 <= bus.instr_rs1;
      r_rs2 <= bus.instr_rs2;
    end
  end
  // operand fetch; ALU inputs hold between instructions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= '0;
      r_in1 <= '0;
      r_in2 <= '0;
    end else if (r_state == S_READ) begin
      r_sel <= r_op;
      r_in1 <= r_rf[r_rs1];
      r_in2 <= r_rf[r_rs2];
    end
  end
  // capture the settled ALU result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
      r_co <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_res <= bus.alu_out;
      r_co <= bus.alu_co;
    end
  end
  // writeback of result and carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_carry <= 1'b0;
    end else if (r_state == S_WB) begin
      r_rf[r_rd] <= r_res;
      r_carry <= r_co;
    end
  end
endmodule
